// File: rtl/prim_ram_1p_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package prim_ram_1p_arb_pkg;

  localparam int unsigned MaxHosts = 8;

  typedef enum logic {
    INIT   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_e;

  // Index width for a host count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_rr_arb.sv
// Combinational round-robin arbiter; the pointer moves past the winner on each grant.
module prim_rr_arb
  import prim_ram_1p_arb_pkg::*;
#(
  parameter int unsigned NumHosts = 2,
  localparam int unsigned IdxW = idx_width(NumHosts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumHosts-1:0] req_i,
  input  logic                adv_i,
  output logic [NumHosts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      if (!valid_o && req_i[IdxW'((32'(ptr_q) + i) % NumHosts)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'((32'(ptr_q) + i) % NumHosts);
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && valid_o) begin
      ptr_d = (32'(idx_o) == NumHosts - 1) ? '0 : IdxW'(idx_o + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Zero-fills a single-port RAM after reset, then shares it round-robin between hosts.
// Define PRIM_RAM_1P_ARB_RDATA_REG_EN to add a register stage on the response path.
module prim_ram_1p_arb
  import prim_ram_1p_arb_pkg::*;
#(
  parameter int unsigned NumHosts    = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 128,
  parameter bit          InitOnReset = 1'b1,
  localparam int unsigned Aw         = $clog2(Depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumHosts-1:0]            host_req_i,
  input  logic [NumHosts-1:0]            host_we_i,
  input  logic [NumHosts-1:0][Aw-1:0]    host_addr_i,
  input  logic [NumHosts-1:0][Width-1:0] host_wdata_i,
  input  logic [NumHosts-1:0][Width-1:0] host_wmask_i,
  output logic [NumHosts-1:0]            host_gnt_o,
  output logic [NumHosts-1:0]            host_rvalid_o,
  output logic [Width-1:0]               host_rdata_o,
  output logic                           ram_req_o,
  output logic                           ram_write_o,
  output logic [Aw-1:0]                  ram_addr_o,
  output logic [Width-1:0]               ram_wdata_o,
  output logic [Width-1:0]               ram_wmask_o,
  input  logic [Width-1:0]               ram_rdata_i,
  output logic                           init_done_o
);

  localparam int unsigned IdxW = idx_width(NumHosts);

  arb_state_e           state_q, state_d;
  logic [Aw-1:0]        init_cnt_q, init_cnt_d;
  logic                 active;
  logic [NumHosts-1:0]  arb_req, arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_any;
  logic [NumHosts-1:0]  rvalid_q;
  logic                 rwe_q;

  // Reset gates the RAM port immediately, not just at the next edge.
  assign active  = (state_q == ACTIVE) && rst_ni;
  assign arb_req = active ? host_req_i : '0;

  prim_rr_arb #(
    .NumHosts (NumHosts)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (arb_req),
    .adv_i   (active),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = host_wmask_i[arb_idx];
    host_gnt_o  = '0;
    init_done_o = 1'b0;
    unique case (state_q)
      INIT: begin
        ram_wmask_o = '1;
        ram_req_o   = rst_ni;
        ram_write_o = rst_ni;
        ram_addr_o  = init_cnt_q;
        if (init_cnt_q == Aw'(Depth - 1)) begin
          state_d = ACTIVE;
        end else begin
          init_cnt_d = Aw'(init_cnt_q + 1'b1);
        end
      end
      ACTIVE: begin
        init_done_o = rst_ni;
        host_gnt_o  = arb_gnt;
        ram_req_o   = arb_any;
        if (arb_any) begin
          ram_write_o = host_we_i[arb_idx];
          ram_addr_o  = host_addr_i[arb_idx];
          ram_wdata_o = host_wdata_i[arb_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= InitOnReset ? INIT : ACTIVE;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Response tag: one-hot granted host plus write flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rwe_q    <= 1'b0;
    end else begin
      rvalid_q <= arb_gnt;
      rwe_q    <= arb_any & host_we_i[arb_idx];
    end
  end

`ifdef PRIM_RAM_1P_ARB_RDATA_REG_EN
  logic [NumHosts-1:0] rvalid2_q;
  logic [Width-1:0]    rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid2_q <= '0;
      rdata_q   <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      rdata_q   <= ((|rvalid_q) && !rwe_q) ? ram_rdata_i : '0;
    end
  end

  assign host_rvalid_o = rvalid2_q;
  assign host_rdata_o  = rdata_q;
`else
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = ((|rvalid_q) && !rwe_q) ? ram_rdata_i : '0;
`endif

endmodule
